// File: rtl/sample_prefetch_pkg.sv
// sample_prefetch_pkg
//   Shared definitions for the sample prefetcher: the fetch FSM state
//   encoding and the mid-scale sample value that the PWM stage idles at.
//   No ports; imported by sample_prefetch and sample_fifo.
package sample_prefetch_pkg;

    // Fetch FSM states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        STREAM  = 3'd4
    } fetch_state_t;

    // Unsigned mid-scale: silence for an 8-bit PWM output.
    localparam logic [7:0] SAMPLE_MIDSCALE = 8'h80;

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo
//   Small synchronous byte FIFO. Storage is a register array and the head
//   byte is presented straight from it, so dout is valid (registered) as
//   soon as empty is low and can be consumed in the same cycle as pop.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset, empties the FIFO
//   flush  - synchronous clear, same effect as rst
//   push   - write din at the tail
//   din    - byte to write
//   pop    - discard the head byte
//   dout   - current head byte
//   level  - occupancy, 0..DEPTH
//   full   - level == DEPTH
//   empty  - level == 0
module sample_fifo
    import sample_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Data array needs no reset; contents are only read while non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // The fetch FSM only requests a byte while there is room, so a push
    // into a full FIFO means the request throttling has broken.
    push_while_full_a: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/sample_prefetch.sv
// sample_prefetch
//   Streams unsigned 8-bit audio samples from serial flash into a small
//   FIFO and releases one sample to the PWM stage every SAMPLE_PERIOD
//   clocks. Playback waits (priming) until the FIFO has filled once.
// Optional feature:
//   SAMPLE_PREFETCH_UNDERRUN_CNT_EN - adds underrun_count[15:0], a
//   saturating count of underruns cleared on reset and on enable rising.
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   enable                - stream while high; low aborts and flushes
//   start_addr            - first sample address, taken in START
//   flash_addr            - address presented to the flash controller
//   flash_start_read      - pulse: open a read at flash_addr
//   flash_continue_read   - pulse: fetch the next sequential byte
//   flash_stop_read       - pulse: end the read
//   flash_data/flash_busy - controller byte and busy flag
//   sample / sample_tick  - registered sample and period boundary pulse
//   fifo_level            - FIFO occupancy
//   underrun              - pulse when a tick finds the FIFO empty
module sample_prefetch
    import sample_prefetch_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int SAMPLE_PERIOD = 1200
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [23:0]            start_addr,
    output logic [23:0]            flash_addr,
    output logic                   flash_start_read,
    output logic                   flash_continue_read,
    output logic                   flash_stop_read,
    input  logic [7:0]             flash_data,
    input  logic                   flash_busy,
    output logic [7:0]             sample,
    output logic                   sample_tick,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   underrun
`ifdef SAMPLE_PREFETCH_UNDERRUN_CNT_EN
    , output logic [15:0]          underrun_count
`endif
);

    localparam int CW = $clog2(SAMPLE_PERIOD + 1);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic [23:0]  addr_q;
    logic [CW-1:0] tick_cnt;
    logic         primed;
    logic         run;
    logic         abort;
    logic         counting;
    logic         tick_wrap;
    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic [7:0]   fifo_dout;

    // run: actively streaming this cycle; abort: enable dropped mid-session.
    // Both are masked by rst so reset wins over any in-flight handshake.
    assign run   = !rst && (state != IDLE) && enable;
    assign abort = !rst && (state != IDLE) && !enable;

    // Request pulses come straight from the state, so each lasts exactly
    // the one cycle the FSM spends in START or passes through STREAM.
    assign flash_start_read    = run && (state == START);
    assign flash_continue_read = run && (state == STREAM) && !fifo_full;
    assign flash_stop_read     = abort;
    assign flash_addr          = (state == START) ? start_addr : addr_q;

    assign fifo_push = run && (state == WAIT_LO) && !flash_busy;

    // The counter starts running on the first cycle the FIFO is full and
    // keeps running afterwards even if the FIFO later drains.
    assign counting    = run && (primed || fifo_full);
    assign tick_wrap   = counting && (tick_cnt == CW'(SAMPLE_PERIOD - 1));
    assign sample_tick = tick_wrap;
    assign underrun    = tick_wrap && fifo_empty;
    assign fifo_pop    = tick_wrap && !fifo_empty;

    // Next-state logic; a dropped enable overrides every handshake state.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (enable)      state_nxt = START;
            START:                    state_nxt = WAIT_HI;
            WAIT_HI: if (flash_busy)  state_nxt = WAIT_LO;
            WAIT_LO: if (!flash_busy) state_nxt = STREAM;
            STREAM:  if (!fifo_full)  state_nxt = WAIT_HI;
            default:                  state_nxt = IDLE;
        endcase
        if (state != IDLE && !enable) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Hold the session start address; the controller owns sequencing.
    always_ff @(posedge clk) begin
        if (rst)                 addr_q <= '0;
        else if (state == START) addr_q <= start_addr;
    end

    // Priming flag and sample-period counter, both cleared outside a session.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            primed   <= 1'b0;
            tick_cnt <= '0;
        end else begin
            if (fifo_full) primed <= 1'b1;
            if (counting) tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
        end
    end

    // Output sample: returns to mid-scale on abort, holds through underruns.
    always_ff @(posedge clk) begin
        if (rst || abort) sample <= SAMPLE_MIDSCALE;
        else if (fifo_pop) sample <= fifo_dout;
    end

    sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (abort),
        .push  (fifo_push),
        .din   (flash_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef SAMPLE_PREFETCH_UNDERRUN_CNT_EN
    logic enable_q;

    // Saturating underrun counter, restarted for each new session.
    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q       <= 1'b0;
            underrun_count <= '0;
        end else begin
            enable_q <= enable;
            if (enable && !enable_q)
                underrun_count <= '0;
            else if (underrun && underrun_count != 16'hFFFF)
                underrun_count <= underrun_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sample_prefetch.sv
// tb_sample_prefetch
//   Bench for sample_prefetch: a flash controller model answers read
//   requests, a queue-based model predicts every output each cycle, and
//   directed scenarios pin literal values. Honours
//   SAMPLE_PREFETCH_UNDERRUN_CNT_EN when it is defined.
module tb_sample_prefetch;

    localparam int DEPTH    = 4;
    localparam int PERIOD   = 1200;
    localparam int BUSY_LEN = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [23:0] start_addr;
    logic [23:0] flash_addr;
    logic        flash_start_read;
    logic        flash_continue_read;
    logic        flash_stop_read;
    logic [7:0]  flash_data;
    logic        flash_busy;
    logic [7:0]  sample;
    logic        sample_tick;
    logic [2:0]  fifo_level;
    logic        underrun;
`ifdef SAMPLE_PREFETCH_UNDERRUN_CNT_EN
    logic [15:0] underrun_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sample_prefetch #(
        .DEPTH         (DEPTH),
        .SAMPLE_PERIOD (PERIOD)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .enable              (enable),
        .start_addr          (start_addr),
        .flash_addr          (flash_addr),
        .flash_start_read    (flash_start_read),
        .flash_continue_read (flash_continue_read),
        .flash_stop_read     (flash_stop_read),
        .flash_data          (flash_data),
        .flash_busy          (flash_busy),
        .sample              (sample),
        .sample_tick         (sample_tick),
        .fifo_level          (fifo_level),
        .underrun            (underrun)
`ifdef SAMPLE_PREFETCH_UNDERRUN_CNT_EN
        , .underrun_count    (underrun_count)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic reportTimeout(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: bound expired, got no event, expected one", name);
    endtask

    task automatic applyStimulus(input logic r, input logic en, input logic [23:0] addr);
        @(posedge clk);
        #1;
        rst        = r;
        enable     = en;
        start_addr = addr;
    endtask

    // ---------------- flash controller model ----------------
    logic [7:0] byteMem [16];
    int   cyc       = 0;
    int   holdUntil = 0;
    int   busyCnt   = 0;
    int   idx       = 0;
    logic reqSeen, startSeen, stopSeen, rstSeen;

    always @(negedge clk) begin
        reqSeen   = flash_start_read | flash_continue_read;
        startSeen = flash_start_read;
        stopSeen  = flash_stop_read;
        rstSeen   = rst;
    end

    // Busy rises the cycle after a request, stays high BUSY_LEN cycles
    // (longer if holdUntil is in the future), then falls with the byte.
    initial begin
        flash_busy = 1'b0;
        flash_data = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rstSeen === 1'b1 || stopSeen === 1'b1) begin
                busyCnt    = 0;
                flash_busy = 1'b0;
            end else if (reqSeen === 1'b1) begin
                if (startSeen === 1'b1) idx = 0;
                busyCnt    = BUSY_LEN;
                flash_busy = 1'b1;
            end else if (busyCnt > 0) begin
                if (busyCnt > 1 || cyc >= holdUntil) busyCnt--;
                if (busyCnt == 0) begin
                    flash_busy = 1'b0;
                    flash_data = byteMem[idx % 16];
                    idx++;
                end
            end
        end
    end

    // ---------------- behavioural model ----------------
    logic [7:0] q[$];
    bit   mValid = 0, mOn = 0, mStartDue = 0, mReq = 0, mBusySeen = 0, mPrimed = 0, mPrevEn = 0;
    int   mCnt = 0;
    int   mUrCnt = 0;
    logic [7:0] mSample = 8'h80;

    function automatic bit expRun();
        return (rst == 1'b0) && mOn && (enable == 1'b1);
    endfunction

    function automatic bit expTick();
        return expRun() && (mPrimed || q.size() == DEPTH) && (mCnt == PERIOD - 1);
    endfunction

    always @(posedge clk) begin
        bit tk, doPush, wasFull;
        if (rst === 1'b1) begin
            mValid = 1; mOn = 0; mPrimed = 0; mPrevEn = 0;
            q.delete(); mCnt = 0; mSample = 8'h80; mUrCnt = 0;
        end else if (mValid) begin
            tk = expTick();
            if (enable && !mPrevEn) mUrCnt = 0;
            else if (tk && q.size() == 0 && mUrCnt < 65535) mUrCnt++;
            mPrevEn = enable;
            if (!mOn) begin
                if (enable) begin
                    mOn = 1; mStartDue = 1; mReq = 0; mPrimed = 0; mCnt = 0;
                end
            end else if (!enable) begin
                mOn = 0; q.delete(); mSample = 8'h80; mCnt = 0; mPrimed = 0;
            end else begin
                doPush  = 0;
                wasFull = (q.size() == DEPTH);
                if (mStartDue) begin
                    mStartDue = 0; mReq = 1; mBusySeen = 0;
                end else if (mReq) begin
                    if (!mBusySeen) begin
                        if (flash_busy) mBusySeen = 1;
                    end else if (!flash_busy) begin
                        doPush = 1; mReq = 0;
                    end
                end else if (!wasFull) begin
                    mReq = 1; mBusySeen = 0;
                end
                if (mPrimed || wasFull) begin
                    mPrimed = 1;
                    mCnt = (mCnt == PERIOD - 1) ? 0 : mCnt + 1;
                end
                if (tk && q.size() > 0) mSample = q.pop_front();
                if (doPush) q.push_back(flash_data);
            end
        end
    end

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (mValid) begin
            checkOutput("level", fifo_level, q.size());
            checkOutput("sample", sample, mSample);
            checkOutput("tick", sample_tick, expTick());
            checkOutput("underrun", underrun, expTick() && q.size() == 0);
            checkOutput("start_read", flash_start_read, expRun() && mStartDue);
            checkOutput("continue_read", flash_continue_read,
                        expRun() && !mStartDue && !mReq && q.size() < DEPTH);
            checkOutput("stop_read", flash_stop_read, (rst == 1'b0) && mOn && (enable == 1'b0));
            if (expRun() && mStartDue) checkOutput("flash_addr", flash_addr, start_addr);
`ifdef SAMPLE_PREFETCH_UNDERRUN_CNT_EN
            checkOutput("underrun_count", underrun_count, mUrCnt);
`endif
        end
    end

    // ---------------- directed scenarios ----------------
    int primeCyc, tc, prevTc, starts, conts, urSeen;
    bit ok;
    logic [7:0] expA [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] expB [7] = '{8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h8D, 8'h8D, 8'h9E};
    logic       urB  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    task automatic loadBytes(input logic [7:0] b0, b1, b2, b3, b4);
        for (int i = 0; i < 16; i++) byteMem[i] = 8'hF0 + 8'(i);
        byteMem[0] = b0; byteMem[1] = b1; byteMem[2] = b2; byteMem[3] = b3; byteMem[4] = b4;
    endtask

    task automatic waitTick(input string name, output int atCyc, output bit got);
        got = 0; atCyc = 0;
        for (int i = 0; i < 1300; i++) begin
            @(negedge clk);
            if (sample_tick === 1'b1) begin got = 1; atCyc = cyc; break; end
        end
        if (!got) reportTimeout(name);
    endtask

    task automatic waitFull(input string name, output int atCyc, output bit got);
        got = 0; atCyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (fifo_level == 3'd4) begin got = 1; atCyc = cyc; break; end
        end
        if (!got) reportTimeout(name);
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; start_addr = 24'h0;
        loadBytes(8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
        applyStimulus(1'b1, 1'b0, 24'h0);
        applyStimulus(1'b1, 1'b0, 24'h0);
        applyStimulus(1'b0, 1'b0, 24'h0);
        @(negedge clk);
        checkOutput("reset sample", sample, 8'h80);
        checkOutput("reset level", fifo_level, 0);
        checkOutput("reset pulses", {flash_start_read, flash_continue_read, flash_stop_read, sample_tick, underrun}, 0);

        // Session 1: priming and in-order playback.
        $display("[TB] session 1: prime and play");
        applyStimulus(1'b0, 1'b1, 24'h000100);
        starts = 0; conts = 0; ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (flash_start_read === 1'b1) begin
                starts++;
                checkOutput("A start addr", flash_addr, 24'h000100);
            end
            if (flash_continue_read === 1'b1) conts++;
            if (fifo_level == 3'd4) begin ok = 1; primeCyc = cyc; break; end
        end
        if (!ok) reportTimeout("A prime");
        checkOutput("A start pulses", starts, 1);
        checkOutput("A continue pulses", conts, 3);
        prevTc = primeCyc;
        for (int n = 0; n < 4; n++) begin
            waitTick("A tick", tc, ok);
            if (ok) begin
                checkOutput("A tick spacing", tc - prevTc, (n == 0) ? PERIOD - 1 : PERIOD);
                prevTc = tc;
                @(negedge clk);
                checkOutput("A sample", sample, expA[n]);
            end
        end

        // Abort while waiting for busy to fall.
        $display("[TB] abort during WAIT_LO");
        ok = 0;
        for (int i = 0; i < 1300; i++) begin
            @(negedge clk);
            if (flash_continue_read === 1'b1) begin ok = 1; break; end
        end
        if (!ok) reportTimeout("C continue");
        applyStimulus(1'b0, 1'b1, 24'h000100);
        applyStimulus(1'b0, 1'b0, 24'h000100);
        @(negedge clk);
        checkOutput("C stop pulse", flash_stop_read, 1);
        @(negedge clk);
        checkOutput("C stop single", flash_stop_read, 0);
        checkOutput("C level flushed", fifo_level, 0);
        checkOutput("C sample midscale", sample, 8'h80);

        // Session 2: long stall drains the FIFO into two underruns.
        $display("[TB] session 2: underrun");
        loadBytes(8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E);
        applyStimulus(1'b0, 1'b1, 24'h000200);
        waitFull("B prime", primeCyc, ok);
        holdUntil = primeCyc + 7800;
        urSeen = 0;
        for (int n = 0; n < 7; n++) begin
            waitTick("B tick", tc, ok);
            if (ok) begin
                checkOutput("B underrun", underrun, urB[n]);
                if (underrun === 1'b1) urSeen++;
                @(negedge clk);
                checkOutput("B sample", sample, expB[n]);
`ifdef SAMPLE_PREFETCH_UNDERRUN_CNT_EN
                if (n == 5) checkOutput("B underrun_count", underrun_count, 2);
`endif
            end
        end
        checkOutput("B underrun total", urSeen, 2);
        holdUntil = 0;

        // Session 3: push and pop on the same edge at level 2.
        $display("[TB] session 3: simultaneous push/pop");
        applyStimulus(1'b0, 1'b0, 24'h000300);
        applyStimulus(1'b0, 1'b0, 24'h000300);
        loadBytes(8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5);
        applyStimulus(1'b0, 1'b1, 24'h000300);
        waitFull("D prime", primeCyc, ok);
        holdUntil = primeCyc + 3 * PERIOD - 1;
        for (int n = 0; n < 5; n++) begin
            waitTick("D tick", tc, ok);
            if (ok) begin
                if (n == 2) begin
                    checkOutput("D tick cycle", tc, holdUntil);
                    checkOutput("D level before", fifo_level, 2);
                    checkOutput("D no underrun", underrun, 0);
                end
                @(negedge clk);
                if (n == 2) checkOutput("D level kept", fifo_level, 2);
                if (n >= 2) checkOutput("D order", sample, (n == 2) ? 8'hC3 : (n == 3) ? 8'hD4 : 8'hE5);
            end
        end
        holdUntil = 0;

        // Reset mid-stream with enable held high.
        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 1'b1, 24'h000300);
        applyStimulus(1'b0, 1'b1, 24'h000300);
        @(negedge clk);
        checkOutput("E level", fifo_level, 0);
        checkOutput("E sample", sample, 8'h80);
        checkOutput("E pulses", {flash_start_read, flash_continue_read, flash_stop_read, sample_tick}, 0);
        ok = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (flash_start_read === 1'b1) begin
                ok = 1;
                checkOutput("E restart addr", flash_addr, 24'h000300);
                break;
            end
        end
        if (!ok) reportTimeout("E restart");

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
